// File: rtl/rsc_pkg.sv
// rsc_pkg: shared types and constants for the RSC fetch control path
package rsc_pkg;
  localparam int DATA_W = 16;
  localparam logic [1:0] PC_IDLE  = 2'b00;
  localparam logic [1:0] PC_DRIVE = 2'b01;
  localparam logic [1:0] PC_INC   = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PC_OUT,
    S_MEM_RD,
    S_PC_INC,
    S_DISPATCH
  } state_t;
endpackage

// File: rtl/rsc_timeout_ctr.sv
// rsc_timeout_ctr: wait-cycle counter; tc flags the enabled cycle that reaches LIMIT
module rsc_timeout_ctr #(
  parameter int TO_W  = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc = en && (cnt_q == TO_W'(LIMIT - 1));
endmodule

// File: rtl/rsc_fetch_sequencer.sv
// rsc_fetch_sequencer: drives the PC, reads instruction memory and hands words to execute
module rsc_fetch_sequencer #(
  parameter int DATA_W      = rsc_pkg::DATA_W,
  parameter int ADDR_W      = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  output logic [1:0]        pc_enables,
  input  logic [DATA_W-1:0] bus_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       fetch_count,
  output logic              busy,
  output logic              mem_fault
);
  import rsc_pkg::*;
  state_t            st_q, st_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              iv_q, iv_d, fault_q, fault_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic              in_rd, to_tc;
  assign in_rd = st_q == S_MEM_RD;
  rsc_timeout_ctr #(.TO_W(TO_W), .LIMIT(MEM_TIMEOUT)) u_to (
    .clk (clk),
    .rst (rst),
    .clr (!in_rd || mem_ready),
    .en  (in_rd && !mem_ready),
    .tc  (to_tc)
  );
  always_comb begin
    st_d          = st_q;
    ar_d          = ar_q;
    ir_d          = ir_q;
    iv_d          = iv_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;
    case (st_q)
      S_IDLE:     st_d = (start && !halt && !fault_q) ? S_PC_OUT : S_IDLE;
      S_PC_OUT: begin
        ar_d = bus_in[ADDR_W-1:0];
        st_d = S_MEM_RD;
      end
      // ready on the terminal wait cycle still wins over the fault
      S_MEM_RD: begin
        if (mem_ready) begin
          ir_d = mem_data;
          st_d = S_PC_INC;
        end else if (to_tc) begin
          fault_d = 1'b1;
          st_d    = S_IDLE;
        end
      end
      S_PC_INC: begin
        iv_d = 1'b1;
        st_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (iv_q && instr_ready) begin
          iv_d          = 1'b0;
          fetch_count_d = fetch_count_q + 1'b1;
          st_d          = halt ? S_IDLE : S_PC_OUT;
        end
      end
      default:    st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= S_IDLE;
      ar_q          <= '0;
      ir_q          <= '0;
      iv_q          <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      st_q          <= st_d;
      ar_q          <= ar_d;
      ir_q          <= ir_d;
      iv_q          <= iv_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign pc_enables  = st_q == S_PC_OUT ? PC_DRIVE : st_q == S_PC_INC ? PC_INC : PC_IDLE;
  assign mem_rd      = in_rd;
  assign mem_addr    = ar_q;
  assign instr       = ir_q;
  assign instr_valid = iv_q;
  assign fetch_count = fetch_count_q;
  assign busy        = st_q != S_IDLE;
  assign mem_fault   = fault_q;
endmodule
